// File: rtl/dnn_pkg.sv
// Shared types and helpers for the DNN output-stage blocks.
package dnn_pkg;

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} acc_state_e;

  function automatic int unsigned clog2_min1(input int unsigned x);
    return (x <= 32'd2) ? 32'd1 : 32'($clog2(x));
  endfunction

  // Most negative two's-complement value of width w, right-aligned in 64 bits.
  function automatic logic [63:0] most_neg(input int unsigned w);
    return 64'd1 << (w - 32'd1);
  endfunction

endpackage

// File: rtl/max_finder_lanes.sv
// Combinational max over N signed lanes as a balanced tree; ties go to the lower lane.
module max_finder_lanes
  import dnn_pkg::*;
#(
  parameter  int unsigned width = 10,
  parameter  int unsigned N     = 1,
  localparam int unsigned LW    = clog2_min1(N)
) (
  input  logic [width*N-1:0]      i_act,
  output logic signed [width-1:0] o_max_c,
  output logic [LW-1:0]           o_idx_c
);

  generate
    if (N == 1) begin : g_leaf
      assign o_max_c = $signed(i_act);
      assign o_idx_c = '0;
    end else begin : g_node
      localparam int unsigned H  = N / 2;
      localparam int unsigned SW = clog2_min1(H);

      logic signed [width-1:0] w_lo_max;
      logic signed [width-1:0] w_hi_max;
      logic [SW-1:0]           w_lo_idx;
      logic [SW-1:0]           w_hi_idx;
      logic                    w_take_hi;

      max_finder_lanes #(.width(width), .N(H)) u_lo (
        .i_act   (i_act[width*H-1:0]),
        .o_max_c (w_lo_max),
        .o_idx_c (w_lo_idx)
      );

      max_finder_lanes #(.width(width), .N(H)) u_hi (
        .i_act   (i_act[width*N-1:width*H]),
        .o_max_c (w_hi_max),
        .o_idx_c (w_hi_idx)
      );

      // Upper half must be strictly greater to win, keeping the lower lane on ties.
      assign w_take_hi = w_hi_max > w_lo_max;
      assign o_max_c   = w_take_hi ? w_hi_max : w_lo_max;
      assign o_idx_c   = w_take_hi ? LW'(H) + LW'(w_hi_idx) : LW'(w_lo_idx);
    end
  endgenerate

endmodule

// File: rtl/argmax_output_tracker.sv
// Output-layer argmax tracker: running max over n_out activations streamed N per beat,
// one-hot class, correctness flag and saturating tally. ARGMAX_TOP2_EN adds runner-up tracking.
module argmax_output_tracker
  import dnn_pkg::*;
#(
  parameter  int unsigned width = 10,
  parameter  int unsigned N     = 1,
  parameter  int unsigned n_out = 4,
  parameter  int unsigned cnt_w = 16,
  localparam int unsigned IDX_W = clog2_min1(n_out)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_act_valid,
  input  logic [width*N-1:0] i_act_in,
  input  logic [N-1:0]       i_y_in,
  output logic               o_busy,
  output logic               o_done,
  output logic [n_out-1:0]   o_a_out_alln,
  output logic [IDX_W-1:0]   o_max_idx,
  output logic [IDX_W-1:0]   o_y_idx,
  output logic               o_correct,
  output logic [cnt_w-1:0]   o_correct_count
`ifdef ARGMAX_TOP2_EN
  ,
  output logic [IDX_W-1:0]   o_second_idx,
  output logic               o_top2_correct,
  output logic [cnt_w-1:0]   o_top2_count
`endif
);

  localparam int unsigned BEATS  = n_out / N;
  localparam int unsigned BEAT_W = clog2_min1(BEATS);
  localparam int unsigned LANE_W = clog2_min1(N);
  localparam logic signed [width-1:0] MOST_NEG = width'(most_neg(width));

  acc_state_e              r_state;
  logic [BEAT_W-1:0]       r_beat;
  logic signed [width-1:0] r_max;
  logic [IDX_W-1:0]        r_max_idx;
  logic [IDX_W-1:0]        r_y_run;

  logic                    w_accept;
  logic                    w_last;
  logic [BEAT_W-1:0]       w_beat;
  logic signed [width-1:0] w_base_max;
  logic signed [width-1:0] w_lane_max;
  logic signed [width-1:0] w_new_max;
  logic [LANE_W-1:0]       w_lane_idx;
  logic [IDX_W-1:0]        w_base_idx;
  logic [IDX_W-1:0]        w_base_y;
  logic [IDX_W-1:0]        w_beat_off;
  logic [IDX_W-1:0]        w_new_idx;
  logic [IDX_W-1:0]        w_new_y;
  logic                    w_new_correct;

  max_finder_lanes #(.width(width), .N(N)) u_lanes (
    .i_act   (i_act_in),
    .o_max_c (w_lane_max),
    .o_idx_c (w_lane_idx)
  );

  // A start restarts from beat 0 with a cleared running state, even mid-sample.
  assign w_accept   = i_act_valid && (i_start || (r_state == ACCUM));
  assign w_beat     = i_start ? '0 : r_beat;
  assign w_last     = (w_beat == BEAT_W'(BEATS - 1));
  assign w_base_max = i_start ? MOST_NEG : r_max;
  assign w_base_idx = i_start ? '0 : r_max_idx;
  assign w_base_y   = i_start ? '0 : r_y_run;
  assign w_beat_off = IDX_W'(w_beat) * IDX_W'(N);

  assign w_new_max     = (w_lane_max > w_base_max) ? w_lane_max : w_base_max;
  assign w_new_idx     = (w_lane_max > w_base_max) ? w_beat_off + IDX_W'(w_lane_idx) : w_base_idx;
  assign w_new_correct = (w_new_idx == w_new_y);

  // Lowest set ideal bit of this beat, if any.
  always_comb begin
    w_new_y = w_base_y;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (i_y_in[k]) w_new_y = w_beat_off + IDX_W'(k);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= IDLE;
      r_beat          <= '0;
      r_max           <= MOST_NEG;
      r_max_idx       <= '0;
      r_y_run         <= '0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_a_out_alln    <= '0;
      o_max_idx       <= '0;
      o_y_idx         <= '0;
      o_correct       <= 1'b0;
      o_correct_count <= '0;
    end else begin
      o_done <= 1'b0;
      if (w_accept) begin
        r_max     <= w_new_max;
        r_max_idx <= w_new_idx;
        r_y_run   <= w_new_y;
        if (w_last) begin
          r_state      <= IDLE;
          o_busy       <= 1'b0;
          r_beat       <= '0;
          o_done       <= 1'b1;
          o_a_out_alln <= n_out'(1) << w_new_idx;
          o_max_idx    <= w_new_idx;
          o_y_idx      <= w_new_y;
          o_correct    <= w_new_correct;
          if (w_new_correct && (o_correct_count != '1))
            o_correct_count <= o_correct_count + cnt_w'(1);
        end else begin
          r_state <= ACCUM;
          o_busy  <= 1'b1;
          r_beat  <= w_beat + BEAT_W'(1);
        end
      end else if (i_start) begin
        r_state   <= ACCUM;
        o_busy    <= 1'b1;
        r_beat    <= '0;
        r_max     <= MOST_NEG;
        r_max_idx <= '0;
        r_y_run   <= '0;
      end
    end
  end

`ifdef ARGMAX_TOP2_EN
  logic signed [width-1:0] r_sec_max;
  logic [IDX_W-1:0]        r_sec_idx;
  logic                    r_f1;
  logic                    r_f2;

  logic signed [width-1:0] w_m1;
  logic signed [width-1:0] w_m2;
  logic signed [width-1:0] w_v;
  logic [IDX_W-1:0]        w_i1;
  logic [IDX_W-1:0]        w_i2;
  logic                    w_f1;
  logic                    w_f2;
  logic                    w_top2;

  // Insert each lane in index order into the (first, second) pair; flags mark filled slots.
  always_comb begin
    w_m1 = w_base_max;
    w_i1 = w_base_idx;
    w_f1 = !i_start && r_f1;
    w_m2 = i_start ? MOST_NEG : r_sec_max;
    w_i2 = i_start ? '0 : r_sec_idx;
    w_f2 = !i_start && r_f2;
    w_v  = '0;
    for (int k = 0; k < int'(N); k++) begin
      w_v = $signed(i_act_in[width*k +: width]);
      if (!w_f1 || (w_v > w_m1)) begin
        if (w_f1) begin
          w_m2 = w_m1;
          w_i2 = w_i1;
          w_f2 = 1'b1;
        end
        w_m1 = w_v;
        w_i1 = w_beat_off + IDX_W'(k);
        w_f1 = 1'b1;
      end else if (!w_f2 || (w_v > w_m2)) begin
        w_m2 = w_v;
        w_i2 = w_beat_off + IDX_W'(k);
        w_f2 = 1'b1;
      end
    end
  end

  assign w_top2 = w_new_correct || (w_i2 == w_new_y);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sec_max      <= MOST_NEG;
      r_sec_idx      <= '0;
      r_f1           <= 1'b0;
      r_f2           <= 1'b0;
      o_second_idx   <= '0;
      o_top2_correct <= 1'b0;
      o_top2_count   <= '0;
    end else if (w_accept) begin
      r_sec_max <= w_m2;
      r_sec_idx <= w_i2;
      r_f1      <= w_f1;
      r_f2      <= w_f2;
      if (w_last) begin
        o_second_idx   <= w_i2;
        o_top2_correct <= w_top2;
        if (w_top2 && (o_top2_count != '1))
          o_top2_count <= o_top2_count + cnt_w'(1);
      end
    end else if (i_start) begin
      r_sec_max <= MOST_NEG;
      r_sec_idx <= '0;
      r_f1      <= 1'b0;
      r_f2      <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_argmax_output_tracker.sv
// Self-checking bench for argmax_output_tracker: three configurations against a scan-based model.
// Also exercises ARGMAX_TOP2_EN outputs when that macro is defined.
module tb_argmax_output_tracker;

  localparam int unsigned W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: 4 neurons, 1 lane; B: 8 neurons, 2 lanes, 2-bit counters; C: 2 neurons in a single beat
  logic a_rst, a_start, a_valid, a_busy, a_done, a_correct;
  logic [W-1:0] a_act;
  logic [0:0] a_y;
  logic [3:0] a_onehot;
  logic [1:0] a_max, a_yidx;
  logic [15:0] a_cnt;

  logic bc_rst, b_start, b_valid, b_busy, b_done, b_correct;
  logic [2*W-1:0] b_act;
  logic [1:0] b_y, b_cnt;
  logic [7:0] b_onehot;
  logic [2:0] b_max, b_yidx;

  logic c_start, c_valid, c_busy, c_done, c_correct;
  logic [2*W-1:0] c_act;
  logic [1:0] c_y, c_onehot;
  logic [0:0] c_max, c_yidx;
  logic [3:0] c_cnt;

`ifdef ARGMAX_TOP2_EN
  logic [1:0] a_sec;
  logic a_t2c;
  logic [15:0] a_t2cnt;
  logic [2:0] b_sec;
  logic b_t2c;
  logic [1:0] b_t2cnt;
  logic [0:0] c_sec;
  logic c_t2c;
  logic [3:0] c_t2cnt;
`endif

  argmax_output_tracker #(.width(W), .N(1), .n_out(4), .cnt_w(16)) dut (
    .i_clk(clk), .i_reset(a_rst), .i_start(a_start), .i_act_valid(a_valid),
    .i_act_in(a_act), .i_y_in(a_y), .o_busy(a_busy), .o_done(a_done),
    .o_a_out_alln(a_onehot), .o_max_idx(a_max), .o_y_idx(a_yidx),
    .o_correct(a_correct), .o_correct_count(a_cnt)
`ifdef ARGMAX_TOP2_EN
    , .o_second_idx(a_sec), .o_top2_correct(a_t2c), .o_top2_count(a_t2cnt)
`endif
  );

  argmax_output_tracker #(.width(W), .N(2), .n_out(8), .cnt_w(2)) dut_b (
    .i_clk(clk), .i_reset(bc_rst), .i_start(b_start), .i_act_valid(b_valid),
    .i_act_in(b_act), .i_y_in(b_y), .o_busy(b_busy), .o_done(b_done),
    .o_a_out_alln(b_onehot), .o_max_idx(b_max), .o_y_idx(b_yidx),
    .o_correct(b_correct), .o_correct_count(b_cnt)
`ifdef ARGMAX_TOP2_EN
    , .o_second_idx(b_sec), .o_top2_correct(b_t2c), .o_top2_count(b_t2cnt)
`endif
  );

  argmax_output_tracker #(.width(W), .N(2), .n_out(2), .cnt_w(4)) dut_c (
    .i_clk(clk), .i_reset(bc_rst), .i_start(c_start), .i_act_valid(c_valid),
    .i_act_in(c_act), .i_y_in(c_y), .o_busy(c_busy), .o_done(c_done),
    .o_a_out_alln(c_onehot), .o_max_idx(c_max), .o_y_idx(c_yidx),
    .o_correct(c_correct), .o_correct_count(c_cnt)
`ifdef ARGMAX_TOP2_EN
    , .o_second_idx(c_sec), .o_top2_correct(c_t2c), .o_top2_count(c_t2cnt)
`endif
  );

  // Reference model state
  int a_cnt_m = 0, a_t2_m = 0, a_hold = 0;
  int b_cnt_m = 0, b_t2_m = 0, b_hold = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Predicted class: first neuron holding the sample maximum.
  function automatic int ref_argmax(input int q[$]);
    int best = q[0];
    int pos = 0;
    foreach (q[i]) if (q[i] > best) best = q[i];
    for (int i = q.size() - 1; i >= 0; i--) if (q[i] == best) pos = i;
    return pos;
  endfunction

  // Runner-up: first neuron holding the maximum among all others.
  function automatic int ref_second(input int q[$]);
    int top = ref_argmax(q);
    int pos = -1;
    foreach (q[i]) if (i != top && (pos < 0 || q[i] > q[pos])) pos = i;
    return (pos < 0) ? 0 : pos;
  endfunction

  task automatic run_a(input int v[4], input int yi, input int gap);
    int q[$];
    int p, ye;
    for (int b = 0; b < 4; b++) begin
      a_start = (b == 0);
      a_valid = 1'b1;
      a_act   = W'(v[b]);
      a_y     = (yi == b);
      tick();
      a_start = 1'b0;
      a_valid = 1'b0;
      a_act   = W'($urandom);
      a_y     = 1'($urandom);
      if (b < 3) begin
        check("a_busy_mid", 64'(a_busy), 64'(1));
        check("a_done_early", 64'(a_done), 64'(0));
        check("a_idx_held", 64'(a_max), 64'(a_hold));
        for (int g = 0; g < gap; g++) begin
          tick();
          check("a_done_gap", 64'(a_done), 64'(0));
        end
      end
    end
    foreach (v[i]) q.push_back(v[i]);
    p  = ref_argmax(q);
    ye = (yi < 0) ? 0 : yi;
    if (p == ye && a_cnt_m < 65535) a_cnt_m++;
    a_hold = p;
    check("a_done", 64'(a_done), 64'(1));
    check("a_busy_end", 64'(a_busy), 64'(0));
    check("a_onehot", 64'(a_onehot), 64'(1) << p);
    check("a_max_idx", 64'(a_max), 64'(p));
    check("a_y_idx", 64'(a_yidx), 64'(ye));
    check("a_correct", 64'(a_correct), 64'(p == ye));
    check("a_count", 64'(a_cnt), 64'(a_cnt_m));
`ifdef ARGMAX_TOP2_EN
    begin
      int s;
      bit t2;
      s  = ref_second(q);
      t2 = (p == ye) || (s == ye);
      if (t2 && a_t2_m < 65535) a_t2_m++;
      check("a_second_idx", 64'(a_sec), 64'(s));
      check("a_top2_correct", 64'(a_t2c), 64'(t2));
      check("a_top2_count", 64'(a_t2cnt), 64'(a_t2_m));
    end
`endif
  endtask

  task automatic run_b(input int v[8], input int yi, input int gap);
    int q[$];
    int p, ye;
    for (int b = 0; b < 4; b++) begin
      b_start = (b == 0);
      b_valid = 1'b1;
      b_act   = {W'(v[2*b+1]), W'(v[2*b])};
      b_y     = {(yi == 2*b+1), (yi == 2*b)};
      tick();
      b_start = 1'b0;
      b_valid = 1'b0;
      b_act   = 20'($urandom);
      b_y     = 2'($urandom);
      if (b < 3) begin
        check("b_done_early", 64'(b_done), 64'(0));
        check("b_idx_held", 64'(b_max), 64'(b_hold));
        for (int g = 0; g < gap; g++) begin
          tick();
          check("b_done_gap", 64'(b_done), 64'(0));
        end
      end
    end
    foreach (v[i]) q.push_back(v[i]);
    p  = ref_argmax(q);
    ye = (yi < 0) ? 0 : yi;
    if (p == ye && b_cnt_m < 3) b_cnt_m++;
    b_hold = p;
    check("b_done", 64'(b_done), 64'(1));
    check("b_onehot", 64'(b_onehot), 64'(1) << p);
    check("b_max_idx", 64'(b_max), 64'(p));
    check("b_y_idx", 64'(b_yidx), 64'(ye));
    check("b_correct", 64'(b_correct), 64'(p == ye));
    check("b_count", 64'(b_cnt), 64'(b_cnt_m));
`ifdef ARGMAX_TOP2_EN
    begin
      int s;
      bit t2;
      s  = ref_second(q);
      t2 = (p == ye) || (s == ye);
      if (t2 && b_t2_m < 3) b_t2_m++;
      check("b_second_idx", 64'(b_sec), 64'(s));
      check("b_top2_count", 64'(b_t2cnt), 64'(b_t2_m));
    end
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset must override a concurrent start with valid data
    a_rst = 1'b1; bc_rst = 1'b1;
    a_start = 1'b1; a_valid = 1'b1; a_act = W'(100); a_y = 1'b1;
    b_start = 1'b0; b_valid = 1'b0; b_act = '0; b_y = '0;
    c_start = 1'b0; c_valid = 1'b0; c_act = '0; c_y = '0;
    tick();
    tick();
    a_rst = 1'b0; bc_rst = 1'b0;
    a_start = 1'b0; a_valid = 1'b0;
    check("rst_busy", 64'(a_busy), 64'(0));
    check("rst_done", 64'(a_done), 64'(0));
    check("rst_onehot", 64'(a_onehot), 64'(0));
    check("rst_max_idx", 64'(a_max), 64'(0));
    check("rst_y_idx", 64'(a_yidx), 64'(0));
    check("rst_correct", 64'(a_correct), 64'(0));
    check("rst_count", 64'(a_cnt), 64'(0));
    check("rst_b_count", 64'(b_cnt), 64'(0));

    run_a('{5, -3, 12, 7}, 2, 0);

    // Ties across lanes and beats, then an all-minimum sample
    run_b('{9, 9, 9, 1, -4, 0, 9, 9}, 0, 0);
    run_b('{-512, -512, -512, -512, -512, -512, -512, -512}, 3, 1);

    // Valid without start while idle is ignored
    a_valid = 1'b1; a_act = W'(300); a_y = 1'b1;
    tick();
    a_valid = 1'b0;
    check("ign_busy", 64'(a_busy), 64'(0));
    check("ign_done", 64'(a_done), 64'(0));
    check("ign_idx", 64'(a_max), 64'(a_hold));

    run_a('{-20, 44, 44, -100}, 1, 3);

    // Abort: two beats of a large-valued sample, then a restart
    a_start = 1'b1; a_valid = 1'b1; a_act = W'(100); a_y = 1'b0;
    tick();
    a_start = 1'b0; a_act = W'(90);
    tick();
    a_valid = 1'b0;
    check("abort_busy", 64'(a_busy), 64'(1));
    check("abort_done", 64'(a_done), 64'(0));
    run_a('{1, 2, 3, 40}, 0, 0);

    // Reset in the middle of a sample
    a_start = 1'b1; a_valid = 1'b1; a_act = W'(50); a_y = 1'b0;
    tick();
    a_start = 1'b0; a_act = W'(-7);
    tick();
    a_valid = 1'b0;
    check("mid_busy", 64'(a_busy), 64'(1));
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    a_cnt_m = 0; a_t2_m = 0; a_hold = 0;
    check("mrst_busy", 64'(a_busy), 64'(0));
    check("mrst_done", 64'(a_done), 64'(0));
    check("mrst_onehot", 64'(a_onehot), 64'(0));
    check("mrst_max_idx", 64'(a_max), 64'(0));
    check("mrst_y_idx", 64'(a_yidx), 64'(0));
    check("mrst_correct", 64'(a_correct), 64'(0));
    check("mrst_count", 64'(a_cnt), 64'(0));
`ifdef ARGMAX_TOP2_EN
    check("mrst_second", 64'(a_sec), 64'(0));
    check("mrst_top2_count", 64'(a_t2cnt), 64'(0));
`endif
    run_a('{10, 30, 20, 0}, 2, 0);

    // Correct samples drive the 2-bit tally into saturation
    for (int s = 0; s < 5; s++) begin
      int v[8];
      foreach (v[j]) v[j] = (j == s) ? 200 : j - 8;
      run_b(v, s, 0);
    end

    // Single-beat configuration: done the cycle after start+valid
    c_start = 1'b1; c_valid = 1'b1; c_act = {W'(3), W'(7)}; c_y = 2'b10;
    tick();
    c_start = 1'b0; c_valid = 1'b0;
    check("c1_done", 64'(c_done), 64'(1));
    check("c1_busy", 64'(c_busy), 64'(0));
    check("c1_onehot", 64'(c_onehot), 64'(1));
    check("c1_y_idx", 64'(c_yidx), 64'(1));
    check("c1_correct", 64'(c_correct), 64'(0));
    c_start = 1'b1; c_valid = 1'b1; c_act = {W'(6), W'(-2)}; c_y = 2'b10;
    tick();
    c_start = 1'b0; c_valid = 1'b0;
    check("c2_max_idx", 64'(c_max), 64'(1));
    check("c2_count", 64'(c_cnt), 64'(1));
    c_valid = 1'b1;
    tick();
    c_valid = 1'b0;
    check("c3_ign_done", 64'(c_done), 64'(0));

    for (int s = 0; s < 30; s++) begin
      int v[4];
      int yi;
      bit narrow;
      narrow = 1'($urandom_range(0, 1));
      foreach (v[i]) v[i] = narrow ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 1023)) - 512;
      yi = int'($urandom_range(0, 4)) - 1;
      run_a(v, yi, int'($urandom_range(0, 2)));
    end

    for (int s = 0; s < 20; s++) begin
      int v[8];
      int yi;
      bit narrow;
      narrow = 1'($urandom_range(0, 1));
      foreach (v[i]) v[i] = narrow ? int'($urandom_range(0, 2)) - 1 : int'($urandom_range(0, 1023)) - 512;
      yi = int'($urandom_range(0, 8)) - 1;
      run_b(v, yi, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
